clint_timer: RTL

- Core-local interruptor: the source end of the timer_int / soft_int lines consumed by the machine-mode CSR block.
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a 1-bit msip. All are memory-mapped on a simple valid/ready data-bus port behind the LSU.
- Drives timer_int (mtime >= mtimecmp) and soft_int (msip) as registered, level-sensitive outputs.

---
 rtl/clint_timer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer -- core-local interruptor (CLINT)
//
// Holds the free-running 64-bit mtime counter, the 64-bit mtimecmp compare
// register and the 1-bit msip software-interrupt flag. All three are
// memory-mapped behind a single-outstanding valid/ready bus port. The block
// drives the level-sensitive machine timer and software interrupt lines.
//
// Register map (byte offsets from BASE_ADDR, 64 KiB window):
//     0x0000  msip (bit 0 only)
//     0x4000  mtimecmp[31:0]      0x4004  mtimecmp[63:32]
//     0xBFF8  mtime[31:0]         0xBFFC  mtime[63:32]
//
// Ports:
//     clock, reset_n            system clock, synchronous active-low reset
//     req_valid / req_ready     request handshake
//     req_write, req_addr,
//     req_wdata, req_wstrb      request payload (word-aligned addresses)
//     rsp_valid, rsp_rdata,
//     rsp_err                   one-cycle response, one cycle after accept
//     timer_int                 registered (mtime >= mtimecmp)
//     soft_int                  registered copy of msip
//
// Optional feature: define CLINT_PRESCALE_EN to add a PRESCALE parameter
// and an internal divider so mtime advances once every PRESCALE cycles.
// ---------------------------------------------------------------------------
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter logic [63:0] MTIME_INC = 64'd1
`ifdef CLINT_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE = 100
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_int,
    output logic        soft_int
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [15:0] OFF_MSIP   = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MT_LO  = 16'hBFF8;
    localparam logic [15:0] OFF_MT_HI  = 16'hBFFC;

    state_t      state;
    state_t      state_next;

    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic        msip;

    logic [31:0] offset;
    logic        in_window;
    logic        aligned;
    logic        hit_msip;
    logic        hit_cmp_lo;
    logic        hit_cmp_hi;
    logic        hit_mt_lo;
    logic        hit_mt_hi;
    logic        addr_err;
    logic [31:0] read_val;

    logic        accept;
    logic        wr_en;
    logic        mtime_wr;
    logic        tick;

    // Byte-lane merge used by every write so partial stores only touch the
    // enabled bytes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

    // State register for the two-state request/response handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. req_ready is also held low while
    // reset is asserted so nothing can be accepted on a reset edge.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset_n;
                if (req_valid && reset_n) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Address decode. The window check rejects addresses below BASE_ADDR
    // explicitly, since the subtraction alone would wrap them into range.
    always_comb begin
        offset     = req_addr - BASE_ADDR;
        in_window  = (req_addr >= BASE_ADDR) && (offset[31:16] == 16'h0000);
        aligned    = (req_addr[1:0] == 2'b00);
        hit_msip   = in_window && aligned && (offset[15:0] == OFF_MSIP);
        hit_cmp_lo = in_window && aligned && (offset[15:0] == OFF_CMP_LO);
        hit_cmp_hi = in_window && aligned && (offset[15:0] == OFF_CMP_HI);
        hit_mt_lo  = in_window && aligned && (offset[15:0] == OFF_MT_LO);
        hit_mt_hi  = in_window && aligned && (offset[15:0] == OFF_MT_HI);
        addr_err   = !(hit_msip || hit_cmp_lo || hit_cmp_hi || hit_mt_lo || hit_mt_hi);

        read_val = 32'h0000_0000;
        if (hit_msip) begin
            read_val = {31'h0, msip};
        end else if (hit_cmp_lo) begin
            read_val = mtimecmp[31:0];
        end else if (hit_cmp_hi) begin
            read_val = mtimecmp[63:32];
        end else if (hit_mt_lo) begin
            read_val = mtime[31:0];
        end else if (hit_mt_hi) begin
            read_val = mtime[63:32];
        end
    end

    assign wr_en    = accept && req_write;
    assign mtime_wr = wr_en && (hit_mt_lo || hit_mt_hi);

`ifdef CLINT_PRESCALE_EN
    logic [31:0] pre_cnt;

    assign tick = (pre_cnt == 32'(PRESCALE - 1));

    // Prescale divider; restarts whenever software rewrites mtime so the
    // first increment after a write is a full period away.
    always_ff @(posedge clock) begin
        if (!reset_n || mtime_wr) begin
            pre_cnt <= 32'h0;
        end else if (tick) begin
            pre_cnt <= 32'h0;
        end else begin
            pre_cnt <= pre_cnt + 32'h1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A bus write to either half of mtime replaces the increment for that
    // cycle; unwritten bytes keep their pre-increment value.
    always_comb begin
        mtime_next = tick ? (mtime + MTIME_INC) : mtime;
        if (mtime_wr) begin
            mtime_next = mtime;
            if (hit_mt_lo) begin
                mtime_next[31:0] = merge_bytes(mtime[31:0], req_wdata, req_wstrb);
            end
            if (hit_mt_hi) begin
                mtime_next[63:32] = merge_bytes(mtime[63:32], req_wdata, req_wstrb);
            end
        end
    end

    // Architectural registers and the registered interrupt lines. The
    // interrupt compares use the current (pre-update) register values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            timer_int <= 1'b0;
            soft_int  <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            timer_int <= (mtime >= mtimecmp);
            soft_int  <= msip;
            if (wr_en && hit_msip && req_wstrb[0]) begin
                msip <= req_wdata[0];
            end
            if (wr_en && hit_cmp_lo) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], req_wdata, req_wstrb);
            end
            if (wr_en && hit_cmp_hi) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_wstrb);
            end
        end
    end

    // Response payload, captured at the accept edge. Write acks and error
    // responses return zero data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (req_write || addr_err) ? 32'h0 : read_val;
            rsp_err   <= addr_err;
        end else begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end
    end

endmodule
